// File: rtl/ttl_piso_serializer.sv
// Multi-lane parallel-in/serial-out shifter with a valid/ready load handshake,
// per-frame MSB/LSB-first direction, shift stall and a frame-done pulse.
module ttl_piso_serializer #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH*CHANNELS-1:0]   D,
  input  logic                        LOAD_VALID,
  output logic                        LOAD_READY,
  input  logic                        DIR,
  input  logic                        CLK_EN,
  input  logic [CHANNELS-1:0]         DS,
  output logic [WIDTH*CHANNELS-1:0]   Q,
  output logic [CHANNELS-1:0]         SO,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic [$clog2(WIDTH)-1:0]    BIT_CNT
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                      state_reg, state_next;
  logic                        dir_reg, dir_next;
  logic [WIDTH*CHANNELS-1:0]   q_reg, q_next;
  logic [WIDTH*CHANNELS-1:0]   shifted;
  logic [CW-1:0]               cnt_reg, cnt_next;
  logic                        done_reg, done_next;
  logic                        last_bit;
  logic                        accept;

  // Every lane shifts in lockstep; DS fills the end vacated by the shift.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign shifted[gi*WIDTH +: WIDTH] = dir_reg
          ? {DS[gi], q_reg[gi*WIDTH+WIDTH-1 : gi*WIDTH+1]}
          : {q_reg[gi*WIDTH+WIDTH-2 : gi*WIDTH], DS[gi]};
      assign SO[gi] = dir_reg ? q_reg[gi*WIDTH] : q_reg[gi*WIDTH+WIDTH-1];
    end
  endgenerate

  assign last_bit   = (state_reg == SHIFT) && CLK_EN && (cnt_reg == CW'(WIDTH - 1));
  assign LOAD_READY = (state_reg == IDLE) || last_bit;
  assign accept     = LOAD_VALID && LOAD_READY;

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    done_next  = last_bit;
    // A load on the last bit replaces the final shift, so frames run gap-free.
    if (accept) begin
      q_next     = D;
      cnt_next   = '0;
      dir_next   = DIR;
      state_next = SHIFT;
    end else if (state_reg == SHIFT && CLK_EN) begin
      q_next = shifted;
      if (last_bit) begin
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      dir_reg   <= 1'b0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  assign Q          = q_reg;
  assign BUSY       = (state_reg == SHIFT);
  assign FRAME_DONE = done_reg;
  assign BIT_CNT    = cnt_reg;

endmodule

// File: tb/tb_ttl_piso_serializer.sv
// Directed table-driven bench for ttl_piso_serializer (WIDTH=8, CHANNELS=2),
// plus a hand-written alternating-stall frame sequence.
module tb_ttl_piso_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d;
  logic        lv;
  logic        rdy;
  logic        dir;
  logic        en;
  logic [1:0]  ds;
  logic [15:0] q;
  logic [1:0]  so;
  logic        busy;
  logic        fd;
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttl_piso_serializer #(.WIDTH(8), .CHANNELS(2)) dut (
    .CLK(clk), .RST(rst), .D(d), .LOAD_VALID(lv), .LOAD_READY(rdy),
    .DIR(dir), .CLK_EN(en), .DS(ds), .Q(q), .SO(so), .BUSY(busy),
    .FRAME_DONE(fd), .BIT_CNT(cnt)
  );

  // Inputs held during one cycle and outputs expected in that same cycle.
  typedef struct {
    logic        rst;
    logic        lv;
    logic        dir;
    logic        en;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [1:0]  so;
    logic        busy;
    logic        rdy;
    logic        fd;
    logic [2:0]  cnt;
    logic        chk_q;
    logic [15:0] q;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic l, input logic di, input logic e,
                   input logic [1:0] s, input logic [15:0] dd, input logic [1:0] eso,
                   input logic eb, input logic er, input logic ef, input logic [2:0] ec,
                   input logic cq, input logic [15:0] eq);
    vec_t t;
    t.rst = r; t.lv = l; t.dir = di; t.en = e; t.ds = s; t.d = dd;
    t.so = eso; t.busy = eb; t.rdy = er; t.fd = ef; t.cnt = ec; t.chk_q = cq; t.q = eq;
    vecs.push_back(t);
  endtask

  task automatic shift_rows(input logic l, input logic [1:0] s, input logic [15:0] dd,
                            input logic [15:0] so_seq, input logic [7:0] fd_seq,
                            input logic fin_rdy);
    for (int k = 0; k < 8; k++)
      v(1'b0, l, 1'b0, 1'b1, s, dd, so_seq[15-2*k -: 2], 1'b1,
        (k == 7) ? fin_rdy : 1'b0, fd_seq[7-k], 3'(k), 1'b0, 16'h0);
  endtask

  initial begin
    int seen;
    int enabled;
    vec_t t;

    rst = 1'b1; lv = 1'b0; dir = 1'b0; en = 1'b0; ds = 2'b00; d = 16'h0;

    // Single-lane style frames on both lanes: lane0 A5, lane1 3C, MSB-first.
    v(0,1,0,1,2'b00,16'h3CA5, 2'b00,0,1,0,3'd0, 1,16'h0000);
    shift_rows(1'b0, 2'b00, 16'h0, 16'b01_00_11_10_10_11_00_01, 8'b0, 1'b1);
    v(0,0,0,1,2'b00,16'h0, 2'b00,0,1,1,3'd0, 1,16'h0000);
    // LSB-first, DS=1 fill, loaded in IDLE with CLK_EN low; DIR flips mid-frame.
    v(0,1,1,0,2'b11,16'hF00F, 2'b00,0,1,0,3'd0, 0,16'h0);
    v(0,0,0,1,2'b11,16'h0, 2'b01,1,0,0,3'd0, 1,16'hF00F);
    v(0,0,0,1,2'b11,16'h0, 2'b01,1,0,0,3'd1, 0,16'h0);
    v(0,0,0,1,2'b11,16'h0, 2'b01,1,0,0,3'd2, 0,16'h0);
    v(0,0,0,1,2'b11,16'h0, 2'b01,1,0,0,3'd3, 0,16'h0);
    v(0,0,1,1,2'b11,16'h0, 2'b10,1,0,0,3'd4, 0,16'h0);
    v(0,0,1,1,2'b11,16'h0, 2'b10,1,0,0,3'd5, 0,16'h0);
    v(0,0,0,1,2'b11,16'h0, 2'b10,1,0,0,3'd6, 0,16'h0);
    v(0,0,0,1,2'b11,16'h0, 2'b10,1,1,0,3'd7, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b11,0,1,1,3'd0, 1,16'hFFFF);
    v(0,0,0,1,2'b00,16'h0, 2'b11,0,1,0,3'd0, 1,16'hFFFF);
    // Back-to-back: second word held valid through the first frame.
    v(0,1,0,1,2'b00,16'h00A5, 2'b11,0,1,0,3'd0, 0,16'h0);
    shift_rows(1'b1, 2'b00, 16'hFF3C, 16'b01_00_01_00_00_01_00_01, 8'b0, 1'b1);
    shift_rows(1'b0, 2'b00, 16'h0,    16'b10_10_11_11_11_11_10_10, 8'b1000_0000, 1'b1);
    v(0,0,0,1,2'b00,16'h0, 2'b00,0,1,1,3'd0, 1,16'h0000);
    // Three-cycle stall at BIT_CNT=4.
    v(0,1,0,1,2'b00,16'h3CA5, 2'b00,0,1,0,3'd0, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b01,1,0,0,3'd0, 1,16'h3CA5);
    v(0,0,0,1,2'b00,16'h0, 2'b00,1,0,0,3'd1, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b11,1,0,0,3'd2, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b10,1,0,0,3'd3, 0,16'h0);
    for (int k = 0; k < 3; k++)
      v(0,0,0,0,2'b00,16'h0, 2'b10,1,0,0,3'd4, 1,16'hC050);
    v(0,0,0,1,2'b00,16'h0, 2'b10,1,0,0,3'd4, 1,16'hC050);
    v(0,0,0,1,2'b00,16'h0, 2'b11,1,0,0,3'd5, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b00,1,0,0,3'd6, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b01,1,1,0,3'd7, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b00,0,1,1,3'd0, 1,16'h0000);
    // Reset on the last bit, with a load also offered: no FRAME_DONE follows.
    v(0,1,0,1,2'b00,16'hFFFF, 2'b00,0,1,0,3'd0, 0,16'h0);
    for (int k = 0; k < 7; k++)
      v(0,0,0,1,2'b00,16'h0, 2'b11,1,0,0,3'(k), 0,16'h0);
    v(1,1,0,1,2'b00,16'hFFFF, 2'b11,1,1,0,3'd7, 0,16'h0);
    v(0,0,0,1,2'b00,16'h0, 2'b00,0,1,0,3'd0, 1,16'h0000);
    v(0,0,0,1,2'b00,16'h0, 2'b00,0,1,0,3'd0, 1,16'h0000);
    // Two lanes with differing data and serial-in.
    v(0,1,0,1,2'b01,16'hFF00, 2'b00,0,1,0,3'd0, 0,16'h0);
    shift_rows(1'b0, 2'b01, 16'h0, 16'b10_10_10_10_10_10_10_10, 8'b0, 1'b1);
    v(0,0,0,1,2'b01,16'h0, 2'b01,0,1,1,3'd0, 1,16'h00FF);

    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      @(negedge clk);
      rst = t.rst; lv = t.lv; dir = t.dir; en = t.en; ds = t.ds; d = t.d;
      #1;
      total++;
      if ({so, busy, rdy, fd, cnt} !== {t.so, t.busy, t.rdy, t.fd, t.cnt}) begin
        bad++;
        $display("FAIL row%0d outputs: got so=%b busy=%b rdy=%b fd=%b cnt=%0d, need so=%b busy=%b rdy=%b fd=%b cnt=%0d",
                 i, so, busy, rdy, fd, cnt, t.so, t.busy, t.rdy, t.fd, t.cnt);
      end else begin
        $display("row%0d so=%b busy=%b rdy=%b fd=%b cnt=%0d q=%h", i, so, busy, rdy, fd, cnt, q);
      end
      if (t.chk_q) begin
        total++;
        if (q !== t.q) begin
          bad++;
          $display("FAIL row%0d q: got %h need %h", i, q, t.q);
        end
      end
    end

    // Alternating CLK_EN: frame must take exactly 8 enabled cycles, and READY
    // must stay low while stalled on the last bit.
    @(negedge clk);
    rst = 1'b0; lv = 1'b1; d = 16'h1234; dir = 1'b0; en = 1'b0; ds = 2'b00;
    @(posedge clk);
    seen = 0;
    enabled = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      lv = 1'b0;
      en = i[0];
      #1;
      if (fd) begin
        seen = 1;
      end else begin
        if (cnt == 3'd7 && !en) begin
          total++;
          if (rdy !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready: got %b need 0", rdy);
          end else begin
            $display("stall_ready at cnt=7 rdy=%b", rdy);
          end
        end
        if (en) enabled++;
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL stall_frame_timeout: got no FRAME_DONE within budget, need one");
    end
    total++;
    if (enabled != 8) begin
      bad++;
      $display("FAIL stall_frame_len: got %0d enabled cycles need 8", enabled);
    end else begin
      $display("stall_frame enabled cycles=%0d", enabled);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
